seq_stream_loader: RTL

Converts an ASCII FASTA-style byte stream into ScoreBank load frames. It is the write side of the ScoreBank `ld_sequence`/`data_in` port.

- Bases are encoded 2 bits each and packed into a frame together with the sequence-type code, ID and length.
- Each frame is issued as a one-cycle `ld_sequence` pulse, only while the bank is not `full`.
- The block sits between the host/file byte interface and `ScoreBank_v1`, and replaces testbench-side frame building.

---
 rtl/seq_stream_loader_if.sv | 29 ++
 rtl/seq_stream_loader.sv | 124 ++++++++++++
 2 files changed

// File: rtl/seq_stream_loader_if.sv
// Byte-stream / ScoreBank-load bundle for seq_stream_loader.
// master: host side (bytes in, frames out); slave: the loader itself.
interface seq_stream_loader_if #(
    parameter int ID_WIDTH  = 48,
    parameter int LEN_WIDTH = 12,
    parameter int LENGTH    = 128
);
    localparam int IN_WIDTH = 2 + ID_WIDTH + LEN_WIDTH + 2 * LENGTH;

    logic [7:0]          char_in;
    logic                char_vld;
    logic                char_rdy;
    logic                is_query;
    logic                full;
    logic                ld_sequence;
    logic [0:IN_WIDTH-1] data_out;
    logic                err;
    logic [ID_WIDTH-1:0] seq_count;

    modport master (
        output char_in, char_vld, is_query, full,
        input  char_rdy, ld_sequence, data_out, err, seq_count
    );

    modport slave (
        input  char_in, char_vld, is_query, full,
        output char_rdy, ld_sequence, data_out, err, seq_count
    );
endinterface

// File: rtl/seq_stream_loader.sv
// FASTA byte stream to ScoreBank load-frame packer.
// Ports: clk, rst (async high), bus = slave side of seq_stream_loader_if.
module seq_stream_loader #(
    parameter int ID_WIDTH  = 48,
    parameter int LEN_WIDTH = 12,
    parameter int LENGTH    = 128
) (
    input  logic                clk,
    input  logic                rst,
    seq_stream_loader_if.slave  bus
);
    localparam int IN_WIDTH = 2 + ID_WIDTH + LEN_WIDTH + 2 * LENGTH;
    localparam int BW       = 2 * LENGTH;
    localparam int BIW      = (BW > 2) ? $clog2(BW) : 1;
    localparam logic [LEN_WIDTH-1:0] LEN_MAX = LEN_WIDTH'(LENGTH);

    typedef enum logic [1:0] {COLLECT, SKIP, PEND} state_t;

    state_t              state_q;
    logic [LEN_WIDTH-1:0] len_q;
    logic [0:BW-1]       buf_q;
    logic [1:0]          type_q;
    logic                sol_q;
    logic                ld_q;
    logic                err_q;
    logic [0:IN_WIDTH-1] data_q;
    logic [ID_WIDTH-1:0] cnt_q;

    logic                is_base;
    logic [1:0]          code;
    logic                is_lf;
    logic                is_ign;
    logic                is_hdr;
    logic                xfer;
    logic                len_full;
    logic [BIW-1:0]      bidx;
    logic [ID_WIDTH-1:0] id_sel;

    always_comb begin
        is_base = 1'b0;
        code    = 2'b00;
        case (bus.char_in)
            8'h41, 8'h61: begin is_base = 1'b1; code = 2'b10; end
            8'h47, 8'h67: begin is_base = 1'b1; code = 2'b11; end
            8'h54, 8'h74: begin is_base = 1'b1; code = 2'b00; end
            8'h43, 8'h63: begin is_base = 1'b1; code = 2'b01; end
            default: ;
        endcase
    end

    assign is_lf    = (bus.char_in == 8'h0A);
    assign is_ign   = (bus.char_in == 8'h0D) || (bus.char_in == 8'h20);
    assign is_hdr   = (bus.char_in == 8'h3E);
    assign xfer     = bus.char_vld && (state_q != PEND);
    assign len_full = (len_q == LEN_MAX);
    // Slot index wraps at len==LENGTH, but that case never writes.
    assign bidx     = BIW'({len_q, 1'b0});
    // Queries always carry ID 0.
    assign id_sel   = (type_q == 2'b01) ? '0 : cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= COLLECT;
            len_q   <= '0;
            buf_q   <= '0;
            type_q  <= 2'b00;
            sol_q   <= 1'b1;
            ld_q    <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            ld_q  <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                COLLECT: begin
                    if (xfer) begin
                        sol_q <= is_lf;
                        if (is_lf) begin
                            if (len_q != '0) state_q <= PEND;
                        end else if (is_hdr && sol_q) begin
                            state_q <= SKIP;
                        end else if (is_base) begin
                            if (len_full) begin
                                err_q <= 1'b1;
                            end else begin
                                buf_q[bidx +: 2] <= code;
                                len_q <= len_q + LEN_WIDTH'(1);
                                if (len_q == '0)
                                    type_q <= bus.is_query ? 2'b01 : 2'b10;
                            end
                        end else if (!is_ign) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                SKIP: begin
                    if (xfer && is_lf) begin
                        state_q <= COLLECT;
                        sol_q   <= 1'b1;
                    end
                end
                PEND: begin
                    if (!bus.full) begin
                        data_q  <= {type_q, id_sel, len_q, buf_q};
                        ld_q    <= 1'b1;
                        buf_q   <= '0;
                        len_q   <= '0;
                        state_q <= COLLECT;
                        if (type_q == 2'b10)
                            cnt_q <= cnt_q + ID_WIDTH'(1);
                    end
                end
                default: state_q <= COLLECT;
            endcase
        end
    end

    assign bus.char_rdy    = (state_q != PEND);
    assign bus.ld_sequence = ld_q;
    assign bus.err         = err_q;
    assign bus.data_out    = data_q;
    assign bus.seq_count   = cnt_q;
endmodule
